// File: rtl/loctag_adc_ctrl.sv
// LocTag detector sequencer: powers the LT5534, waits for it to settle, then runs a
// burst of CPOL=1 serial ADC conversions per trigger edge. Optional: LOCTAG_ADC_AUTO_OFF_EN.

module loctag_adc_ctrl #(
    parameter int ADC_BITS      = 12,
    parameter int FRAME_BITS    = 16,
    parameter int CLK_DIV       = 2,
    parameter int SETTLE_CYCLES = 800,
    parameter int QUIET_CYCLES  = 4,
    parameter int BURST_LEN     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                trig,
    output logic                det_en,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic [ADC_BITS-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                burst_done,
    output logic                overflow,
    output logic                busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_ARMED  = 3'd2;
    localparam logic [2:0] ST_CONV   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    localparam int WAIT_MAX = (SETTLE_CYCLES > QUIET_CYCLES) ? SETTLE_CYCLES : QUIET_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int HALF_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int BURST_W  = $clog2(BURST_LEN + 1);

    localparam logic [WAIT_W-1:0]  SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  QUIET_LAST  = WAIT_W'(QUIET_CYCLES - 1);
    localparam logic [HALF_W-1:0]  HALF_LAST   = HALF_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(FRAME_BITS - 1);
    localparam logic [BURST_W-1:0] BURST_FULL  = BURST_W'(BURST_LEN);

    logic [2:0]          state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    // Only the last ADC_BITS captured bits survive; leading frame bits shift out the top.
    logic [ADC_BITS-1:0] shreg;

    logic trig_meta;
    logic trig_sync;
    logic trig_sync_d;
    logic trig_pulse;

    logic half_end;
    logic frame_end;
    logic sample_load;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_meta   <= 1'b0;
            trig_sync   <= 1'b0;
            trig_sync_d <= 1'b0;
            trig_pulse  <= 1'b0;
        end else begin
            trig_meta   <= trig;
            trig_sync   <= trig_meta;
            trig_sync_d <= trig_sync;
            trig_pulse  <= trig_sync & ~trig_sync_d;
        end
    end

    assign half_end    = (half_cnt == HALF_LAST);
    assign frame_end   = (state == ST_CONV) && half_end && adc_sclk && (bit_cnt == BIT_LAST);
    assign sample_load = enable && frame_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            burst_cnt  <= '0;
            shreg      <= '0;
            det_en     <= 1'b0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (!enable) begin
                state    <= ST_IDLE;
                det_en   <= 1'b0;
                adc_cs_n <= 1'b1;
                adc_sclk <= 1'b1;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_WARMUP;
                        det_en   <= 1'b1;
                        wait_cnt <= '0;
                    end
                    ST_WARMUP: begin
                        if (wait_cnt == SETTLE_LAST) begin
                            state <= ST_ARMED;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_pulse) begin
                            burst_cnt <= '0;
                            state     <= ST_CONV;
                            adc_cs_n  <= 1'b0;
                            adc_sclk  <= 1'b0;
                            half_cnt  <= '0;
                            bit_cnt   <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    ST_CONV: begin
                        if (!half_end) begin
                            half_cnt <= half_cnt + 1'b1;
                        end else begin
                            half_cnt <= '0;
                            if (!adc_sclk) begin
                                // Low-to-high SCLK edge: the ADC has held this bit for a full half-period.
                                adc_sclk <= 1'b1;
                                shreg    <= {shreg[ADC_BITS-2:0], adc_sdo};
                            end else if (bit_cnt == BIT_LAST) begin
                                adc_cs_n <= 1'b1;
                                state    <= ST_GAP;
                                wait_cnt <= '0;
                                if (burst_cnt != BURST_FULL) begin
                                    burst_cnt <= burst_cnt + 1'b1;
                                end
                            end else begin
                                adc_sclk <= 1'b0;
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (wait_cnt != QUIET_LAST) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end else if (burst_cnt == BURST_FULL) begin
                            burst_done <= 1'b1;
                            busy       <= 1'b0;
`ifdef LOCTAG_ADC_AUTO_OFF_EN
                            state      <= ST_IDLE;
                            det_en     <= 1'b0;
`else
                            state      <= ST_ARMED;
`endif
                        end else begin
                            state    <= ST_CONV;
                            adc_cs_n <= 1'b0;
                            adc_sclk <= 1'b0;
                            half_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output stream: a full holding register drops new results rather than overwriting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (sample_load) begin
                if (sample_valid && !sample_ready) begin
                    overflow <= 1'b1;
                end else begin
                    sample_data  <= shreg;
                    sample_valid <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (!enable) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/loctag_adc_ctrl.md
# loctag_adc_ctrl

Trigger-driven sequencer for the LocTag detector chain. It powers the LT5534 detector, waits for it to settle, then on each trigger edge runs a burst of serial ADC conversions. Conversions use a CPOL=1, 16-clock frame with a 12-bit payload. Each result is delivered over a valid/ready stream. The block sits between the board pins (`pin_lt5534_en`, `pin_adc_cs`, `pin_adc_clk`, `pin_adc_so`, `pin_trig`) and the logging/telemetry logic.

## Interface
Parameters:
- `ADC_BITS`, 12: payload width; the low `ADC_BITS` of each frame.
- `FRAME_BITS`, 16: SCLK periods per conversion.
- `CLK_DIV`, 2: clk cycles per SCLK half-period (≥1).
- `SETTLE_CYCLES`, 800: detector warm-up, in clk cycles, after `det_en` rises.
- `QUIET_CYCLES`, 4: minimum CS-high time between frames (≥1).
- `BURST_LEN`, 8: conversions per trigger (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; run controller.
- `trig`  in  1  asynchronous trigger (from `pin_trig`).
- `det_en`  out  1  LT5534 enable.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles high.
- `adc_sdo`  in  1  ADC serial data, MSB first.
- `sample_data`  out  ADC_BITS  conversion result.
- `sample_valid`  out  1  result valid.
- `sample_ready`  in  1  consumer accepts.
- `burst_done`  out  1  one-cycle pulse after the last frame of a burst.
- `overflow`  out  1  sticky; a result was dropped.
- `busy`  out  1  high in CONV or GAP.

## Operation
- Reset values: `det_en`=0, `adc_cs_n`=1, `adc_sclk`=1, `sample_data`=0, `sample_valid`=0, `burst_done`=0, `overflow`=0, `busy`=0. The FSM resets to IDLE.
- `trig` passes through a 2-FF synchronizer. A rising-edge detect on the synchronized signal produces `trig_pulse`.
- FSM states and transitions:
  - IDLE: goes to WARMUP when `enable`=1. Sets `det_en`=1.
  - WARMUP: counts `SETTLE_CYCLES`, then goes to ARMED.
  - ARMED: on `trig_pulse`, clears the burst counter and goes to CONV.
  - CONV: drives `adc_cs_n`=0 and clocks `FRAME_BITS` SCLK periods. It then sets `adc_cs_n`=1 and goes to GAP.
  - GAP: counts `QUIET_CYCLES`. If the burst counter equals `BURST_LEN`, it pulses `burst_done` and goes to ARMED. Otherwise it goes to CONV.
- A `trig_pulse` arriving in CONV or GAP is ignored. No queuing.
- SCLK: in each frame the first half-period is low. `adc_sdo` is sampled into a `FRAME_BITS` shift register on each low→high SCLK transition.
- Result: `sample_data` = low `ADC_BITS` of the shift register. It is loaded on CS rise. The burst counter increments at the same point, saturating at `BURST_LEN`.
- Output handshake:
  - If `sample_valid`=1 and `sample_ready`=0 when a new result loads, the new result is dropped, `overflow` is set, and the held data is unchanged.
  - `sample_valid` clears on the cycle that `sample_valid & sample_ready`=1.
  - If a new load coincides with acceptance, the new data loads and `sample_valid` stays 1.
- `enable`=0 in any state aborts immediately on the next clk edge: FSM to IDLE, `adc_cs_n`=1, `adc_sclk`=1, `overflow` cleared. A pending `sample_valid` is kept until it is accepted.

## Timing
- Trigger to CS low is 4 clk edges: 2 synchronizer, 1 edge detect, 1 FSM register.
- Frame length is `2*FRAME_BITS*CLK_DIV` clk cycles with CS low. With defaults that is 64 cycles.
- `sample_valid` rises on the first clk edge with `adc_cs_n`=1.
- Frame-to-frame period within a burst is `2*FRAME_BITS*CLK_DIV + QUIET_CYCLES`. With defaults that is 68 cycles.
- `burst_done` is high for exactly one cycle, at GAP exit.
- All outputs are registered, with no combinational paths from inputs.

## Configuration
- `LOCTAG_ADC_AUTO_OFF_EN` defined:
  - After `burst_done`, the FSM returns to IDLE with `det_en`=0.
  - If `enable` is still 1, it then re-enters WARMUP, so every burst pays `SETTLE_CYCLES` of warm-up.
- `LOCTAG_ADC_AUTO_OFF_EN` undefined:
  - The FSM goes from GAP to ARMED and `det_en` stays 1 while `enable`=1.

## Test plan
- Reset with `enable`=0 for 10 cycles → all outputs at their reset values and `det_en`=0.
- Warm-up and first burst (defaults):
  - Stimulus: `enable`=1, `trig` pulsed 2 cycles after warm-up ends, ADC model returning 0x0ABC in each frame, `sample_ready` tied 1.
  - Response: `adc_cs_n` falls 4 cycles after `trig` rises; 8 frames, each 64 cycles long at a 68-cycle pitch; 8 samples of `sample_data`=0xABC; one `burst_done` pulse.
- Backpressure: `sample_ready`=0 for the whole burst → the first sample (0xABC) is held, `overflow`=1, and the sample is accepted once ready rises.
- Abort: `enable` dropped during the 5th SCLK of a frame → next cycle `adc_cs_n`=1, `adc_sclk`=1, FSM in IDLE, `det_en`=0, no new sample.
- Retrigger during CONV → ignored; the burst still produces exactly `BURST_LEN` samples.
- With `LOCTAG_ADC_AUTO_OFF_EN` defined → `det_en` falls the cycle after `burst_done`, then rises again, and a second `trig` is honoured only after 800 cycles of warm-up.
